// File: rtl/code_lut_pkg.sv
// Shared constants for the octree prefix-code mapper: group bases, prefixes,
// offset widths and total code lengths, plus the group selector enum.
package code_lut_pkg;

  localparam int CODE_W = 16;
  localparam int LEN_W  = 4;

  typedef enum logic [2:0] {
    GRP0 = 3'd0,
    GRP1 = 3'd1,
    GRP2 = 3'd2,
    GRP3 = 3'd3,
    GRP4 = 3'd4
  } group_e;

  // First rank of each group
  localparam logic [7:0] BASE_G0 = 8'd0;
  localparam logic [7:0] BASE_G1 = 8'd4;
  localparam logic [7:0] BASE_G2 = 8'd12;
  localparam logic [7:0] BASE_G3 = 8'd28;
  localparam logic [7:0] BASE_G4 = 8'd92;

  // Unary-style prefixes, right-aligned in 4 bits, with their widths
  localparam logic [3:0] PREFIX_G0 = 4'b0000;
  localparam logic [3:0] PREFIX_G1 = 4'b0010;
  localparam logic [3:0] PREFIX_G2 = 4'b0110;
  localparam logic [3:0] PREFIX_G3 = 4'b1110;
  localparam logic [3:0] PREFIX_G4 = 4'b1111;

  localparam int PRE_W_G0 = 1;
  localparam int PRE_W_G1 = 2;
  localparam int PRE_W_G2 = 3;
  localparam int PRE_W_G3 = 4;
  localparam int PRE_W_G4 = 4;

  // Offset field widths
  localparam int OFF_W_G0 = 2;
  localparam int OFF_W_G1 = 3;
  localparam int OFF_W_G2 = 4;
  localparam int OFF_W_G3 = 6;
  localparam int OFF_W_G4 = 8;

  // Total codeword lengths (prefix width + offset width)
  localparam logic [LEN_W-1:0] LEN_G0 = LEN_W'(PRE_W_G0 + OFF_W_G0);
  localparam logic [LEN_W-1:0] LEN_G1 = LEN_W'(PRE_W_G1 + OFF_W_G1);
  localparam logic [LEN_W-1:0] LEN_G2 = LEN_W'(PRE_W_G2 + OFF_W_G2);
  localparam logic [LEN_W-1:0] LEN_G3 = LEN_W'(PRE_W_G3 + OFF_W_G3);
  localparam logic [LEN_W-1:0] LEN_G4 = LEN_W'(PRE_W_G4 + OFF_W_G4);

endpackage

// File: rtl/code_lut_if.sv
// Rank-in / code-out bundle. The master drives ranks and consumes codes;
// the slave (the mapper) does the opposite.
interface code_lut_if
  import code_lut_pkg::*;
  ();

  logic              i_valid;
  logic [7:0]        i_rank;
  logic              o_valid;
  logic [CODE_W-1:0] o_code;
  logic [LEN_W-1:0]  o_code_len;

  modport master (
    output i_valid,
    output i_rank,
    input  o_valid,
    input  o_code,
    input  o_code_len
  );

  modport slave (
    input  i_valid,
    input  i_rank,
    output o_valid,
    output o_code,
    output o_code_len
  );

endinterface

// File: rtl/code_lut_enc.sv
// Combinational rank -> {codeword, length} encoder. Every 8-bit rank falls
// into exactly one group, so there is no invalid case.
module code_lut_enc
  import code_lut_pkg::*;
  (
    input  logic [7:0]        i_rank,
    output logic [CODE_W-1:0] o_code,
    output logic [LEN_W-1:0]  o_len
  );

  group_e     w_group;
  logic [7:0] w_base;
  logic [7:0] w_diff;

  // Pick the group with unsigned compares against the group bases
  always_comb begin
    w_group = GRP0;
    w_base  = BASE_G0;
    if (i_rank >= BASE_G4) begin
      w_group = GRP4;
      w_base  = BASE_G4;
    end else if (i_rank >= BASE_G3) begin
      w_group = GRP3;
      w_base  = BASE_G3;
    end else if (i_rank >= BASE_G2) begin
      w_group = GRP2;
      w_base  = BASE_G2;
    end else if (i_rank >= BASE_G1) begin
      w_group = GRP1;
      w_base  = BASE_G1;
    end
  end

  assign w_diff = i_rank - w_base;

  // Splice the prefix above the truncated offset for the selected group
  always_comb begin
    o_code = '0;
    o_len  = '0;
    case (w_group)
      GRP0: begin
        o_code = (CODE_W'(PREFIX_G0) << OFF_W_G0) | CODE_W'(w_diff[OFF_W_G0-1:0]);
        o_len  = LEN_G0;
      end
      GRP1: begin
        o_code = (CODE_W'(PREFIX_G1) << OFF_W_G1) | CODE_W'(w_diff[OFF_W_G1-1:0]);
        o_len  = LEN_G1;
      end
      GRP2: begin
        o_code = (CODE_W'(PREFIX_G2) << OFF_W_G2) | CODE_W'(w_diff[OFF_W_G2-1:0]);
        o_len  = LEN_G2;
      end
      GRP3: begin
        o_code = (CODE_W'(PREFIX_G3) << OFF_W_G3) | CODE_W'(w_diff[OFF_W_G3-1:0]);
        o_len  = LEN_G3;
      end
      GRP4: begin
        o_code = (CODE_W'(PREFIX_G4) << OFF_W_G4) | CODE_W'(w_diff[OFF_W_G4-1:0]);
        o_len  = LEN_G4;
      end
      default: begin
        o_code = '0;
        o_len  = '0;
      end
    endcase
  end

endmodule

// File: rtl/code_lut.sv
// Registered prefix-code mapper: one rank in per cycle, its codeword and
// length out one cycle later. Idle and reset cycles present all-zero outputs.
module code_lut
  import code_lut_pkg::*;
  (
    input  logic       i_clk,
    input  logic       i_rst,
    code_lut_if.slave  bus
  );

  logic [CODE_W-1:0] w_code;
  logic [LEN_W-1:0]  w_len;

  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic [LEN_W-1:0]  r_code_len;

  code_lut_enc u_enc (
    .i_rank (bus.i_rank),
    .o_code (w_code),
    .o_len  (w_len)
  );

  // Output register: reset wins, otherwise capture on valid and clear when idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_code     <= '0;
      r_code_len <= '0;
    end else if (bus.i_valid) begin
      r_valid    <= 1'b1;
      r_code     <= w_code;
      r_code_len <= w_len;
    end else begin
      r_valid    <= 1'b0;
      r_code     <= '0;
      r_code_len <= '0;
    end
  end

  assign bus.o_valid    = r_valid;
  assign bus.o_code     = r_code;
  assign bus.o_code_len = r_code_len;

endmodule

// File: tb/tb_code_lut.sv
// Directed bench for code_lut: reset behaviour, group boundaries, a full
// sweep against an arithmetic reference, prefix-freeness, idle and reset cycles.
module tb_code_lut;

  logic i_clk;
  logic i_rst;

  int checks;
  int failures;

  logic [15:0] sweepCode [256];
  logic [3:0]  sweepLen  [256];

  code_lut_if bus ();

  code_lut dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Reference: base code value of each group plus the rank's distance from the base
  function automatic void refCode(input int rank, output logic [15:0] code, output logic [3:0] len);
    if (rank < 4) begin
      code = 16'(rank);
      len  = 4'd3;
    end else if (rank < 12) begin
      code = 16'(16 + rank - 4);
      len  = 4'd5;
    end else if (rank < 28) begin
      code = 16'(96 + rank - 12);
      len  = 4'd7;
    end else if (rank < 92) begin
      code = 16'(896 + rank - 28);
      len  = 4'd10;
    end else begin
      code = 16'(3840 + rank - 92);
      len  = 4'd12;
    end
  endfunction

  // Drive one cycle of inputs at the falling edge, then wait for the next falling edge
  task automatic applyStimulus(input logic rst, input logic valid, input logic [7:0] rank);
    i_rst       = rst;
    bus.i_valid = valid;
    bus.i_rank  = rank;
    @(negedge i_clk);
  endtask

  // Compare the registered outputs against expected values
  task automatic checkOutput(input string tag, input logic expValid,
                             input logic [15:0] expCode, input logic [3:0] expLen);
    checks++;
    assert (bus.o_valid === expValid) else begin
      failures++;
      $error("[TB] FAIL %s valid observed=%0b expected=%0b", tag, bus.o_valid, expValid);
    end
    checks++;
    assert (bus.o_code === expCode) else begin
      failures++;
      $error("[TB] FAIL %s code observed=%0d expected=%0d", tag, bus.o_code, expCode);
    end
    checks++;
    assert (bus.o_code_len === expLen) else begin
      failures++;
      $error("[TB] FAIL %s len observed=%0d expected=%0d", tag, bus.o_code_len, expLen);
    end
  endtask

  // Directed sequence
  initial begin
    logic [15:0] expCode;
    logic [3:0]  expLen;
    int          prefixViolations;

    checks           = 0;
    failures         = 0;
    prefixViolations = 0;
    i_rst            = 1'b1;
    bus.i_valid      = 1'b1;
    bus.i_rank       = 8'd5;
    @(negedge i_clk);

    // Reset held for three cycles with a valid rank present
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 8'd5);
      checkOutput("reset_hold", 1'b0, 16'd0, 4'd0);
    end

    // Release: the first result shows up one cycle later
    applyStimulus(1'b0, 1'b1, 8'd0);
    checkOutput("rank0", 1'b1, 16'd0, 4'd3);
    applyStimulus(1'b0, 1'b1, 8'd3);
    checkOutput("rank3", 1'b1, 16'd3, 4'd3);
    applyStimulus(1'b0, 1'b1, 8'd4);
    checkOutput("rank4", 1'b1, 16'd16, 4'd5);
    applyStimulus(1'b0, 1'b1, 8'd11);
    checkOutput("rank11", 1'b1, 16'd23, 4'd5);
    applyStimulus(1'b0, 1'b1, 8'd12);
    checkOutput("rank12", 1'b1, 16'd96, 4'd7);
    applyStimulus(1'b0, 1'b1, 8'd27);
    checkOutput("rank27", 1'b1, 16'd111, 4'd7);

    // G3/G4 boundaries back-to-back
    applyStimulus(1'b0, 1'b1, 8'd28);
    checkOutput("rank28", 1'b1, 16'd896, 4'd10);
    applyStimulus(1'b0, 1'b1, 8'd91);
    checkOutput("rank91", 1'b1, 16'd959, 4'd10);
    applyStimulus(1'b0, 1'b1, 8'd92);
    checkOutput("rank92", 1'b1, 16'd3840, 4'd12);
    applyStimulus(1'b0, 1'b1, 8'd255);
    checkOutput("rank255", 1'b1, 16'd4003, 4'd12);

    // Exhaustive sweep, one rank per cycle
    for (int r = 0; r < 256; r++) begin
      applyStimulus(1'b0, 1'b1, 8'(r));
      refCode(r, expCode, expLen);
      checkOutput($sformatf("sweep%0d", r), 1'b1, expCode, expLen);
      sweepCode[r] = bus.o_code;
      sweepLen[r]  = bus.o_code_len;
      checks++;
      assert ((bus.o_code >> bus.o_code_len) === 16'd0) else begin
        failures++;
        $error("[TB] FAIL sweep_high%0d observed=%0h expected=0", r, bus.o_code >> bus.o_code_len);
      end
    end

    // No captured code may be a prefix of another
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        if (i != j && sweepLen[i] <= sweepLen[j]) begin
          if ((sweepCode[j] >> (sweepLen[j] - sweepLen[i])) == sweepCode[i])
            prefixViolations++;
        end
      end
    end
    checks++;
    assert (prefixViolations === 0) else begin
      failures++;
      $error("[TB] FAIL prefix_free observed=%0d expected=0", prefixViolations);
    end

    // Valid dropped mid-stream, then reset pulsed while a rank is presented
    applyStimulus(1'b0, 1'b1, 8'd50);
    checkOutput("mid50", 1'b1, 16'd918, 4'd10);
    applyStimulus(1'b0, 1'b0, 8'd77);
    checkOutput("idle", 1'b0, 16'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 8'd7);
    checkOutput("mid7", 1'b1, 16'd19, 4'd5);
    applyStimulus(1'b1, 1'b1, 8'd200);
    checkOutput("reset_pulse", 1'b0, 16'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 8'd200);
    checkOutput("after_reset200", 1'b1, 16'd3948, 4'd12);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("final_idle", 1'b0, 16'd0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
